// File: rtl/spi_pkg.sv
// Shared definitions for the mode-0 SPI byte master: state encoding,
// default word width and the idle levels of the SPI pins.
package spi_pkg;

  localparam int SPI_MAXLEN = 16;

  localparam logic SCK_IDLE  = 1'b0;
  localparam logic SS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } spi_state_e;

  // A zero length still moves one bit; anything longer than the word is cut to the word.
  function automatic logic [4:0] clamp_len(input logic [4:0] len, input int maxlen);
    if (len == 5'd0) return 5'd1;
    if (int'(len) > maxlen) return 5'(maxlen);
    return len;
  endfunction

endpackage

// File: rtl/spi_clkdiv.sv
// Half-period timer for the SPI master: a down-counter that pulses tick on
// the last clock of each DIV-clock half-period and restarts when clr is high.
module spi_clkdiv #(
  parameter int DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int              CW     = $clog2(DIV + 1);
  localparam logic [CW-1:0]   RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == '0);

  // Terminal count reloads as well, so the counter never rolls past zero.
  always_comb begin
    cnt_d = cnt_q - CW'(1);
    if (clr || tick) cnt_d = RELOAD;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_byte_master.sv
// Mode-0 SPI master moving 1..MAXLEN bits MSB-first per request, with a
// req/resp handshake on the SoC side and fully registered pin outputs.
//
// state | meaning
// IDLE  | ready for a request; pins at idle levels
// SETUP | ss low, first bit on mosi, sck low for DIV clocks
// HIGH  | sck high for DIV clocks; miso sampled on entry
// LOW   | sck low for DIV clocks; next bit on mosi on entry
// HOLD  | sck low, ss still low for DIV clocks after the last bit
// DONE  | ss/mosi back to idle, one-cycle resp_valid
module spi_byte_master
  import spi_pkg::*;
#(
  parameter int DIV    = 2,
  parameter int MAXLEN = SPI_MAXLEN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_len,
  input  logic [MAXLEN-1:0] req_data,
  output logic              resp_valid,
  output logic [MAXLEN-1:0] resp_data,
  output logic              sck,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  spi_state_e        state_q, state_d;
  logic [MAXLEN-1:0] tx_q, tx_d;
  logic [MAXLEN-1:0] rx_q, rx_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [MAXLEN-1:0] resp_data_q, resp_data_d;
  logic              sck_q, sck_d;
  logic              ss_q, ss_d;
  logic              mosi_q, mosi_d;
  logic              resp_valid_q, resp_valid_d;
  logic [4:0]        len_eff;
  logic              tick;
  logic              div_clr;

  assign div_clr = (state_d != state_q) || (state_q == ST_IDLE);

  spi_clkdiv #(.DIV(DIV)) u_clkdiv (
    .clock (clock),
    .reset (reset),
    .clr   (div_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_cnt_d   = bit_cnt_q;
    resp_data_d = resp_data_q;
    mosi_d      = mosi_q;
    len_eff     = clamp_len(req_len, MAXLEN);

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          // Left-align so the first bit to send always sits in the MSB.
          tx_d      = req_data << (MAXLEN - int'(len_eff));
          rx_d      = '0;
          bit_cnt_d = len_eff;
          mosi_d    = tx_d[MAXLEN-1];
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP, ST_LOW: begin
        if (tick) begin
          rx_d      = {rx_q[MAXLEN-2:0], miso};
          bit_cnt_d = bit_cnt_q - 5'd1;
          state_d   = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (tick) begin
          if (bit_cnt_q != 5'd0) begin
            tx_d    = tx_q << 1;
            mosi_d  = tx_q[MAXLEN-2];
            state_d = ST_LOW;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          resp_data_d = rx_q;
          mosi_d      = MOSI_IDLE;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Pin levels follow the state being entered so they change with the state register.
    sck_d        = (state_d == ST_HIGH) ? ~SCK_IDLE : SCK_IDLE;
    ss_d         = (state_d == ST_IDLE || state_d == ST_DONE) ? SS_IDLE : ~SS_IDLE;
    resp_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tx_q         <= '0;
      rx_q         <= '0;
      bit_cnt_q    <= '0;
      resp_data_q  <= '0;
      sck_q        <= SCK_IDLE;
      ss_q         <= SS_IDLE;
      mosi_q       <= MOSI_IDLE;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      bit_cnt_q    <= bit_cnt_d;
      resp_data_q  <= resp_data_d;
      sck_q        <= sck_d;
      ss_q         <= ss_d;
      mosi_q       <= mosi_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign sck        = sck_q;
  assign ss         = ss_q;
  assign mosi       = mosi_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: a DIV=2 instance with a selectable
// miso source (loopback, constant 1, shift-out slave) and a DIV=1 instance in loopback.
module tb_spi_byte_master;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        req_valid0, req_valid1;
  logic [4:0]  req_len;
  logic [15:0] req_data;
  logic        req_ready0, resp_valid0, sck0, ss0, mosi0, miso0;
  logic        req_ready1, resp_valid1, sck1, ss1, mosi1, miso1;
  logic [15:0] resp_data0, resp_data1;

  logic [1:0]  miso_mode;
  logic [15:0] slv_word;
  logic [15:0] slv_rx = '0;
  int          slv_edges = 0;
  int          slv_falls = 0;
  int          resp_pulses0 = 0;
  int          edges1 = 0;
  int          sck1_hi = 0;
  logic        slv_miso;

  int checks = 0;
  int errors = 0;

  spi_byte_master #(.DIV(2), .MAXLEN(16)) dut0 (
    .clock(clock), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_len(req_len), .req_data(req_data), .resp_valid(resp_valid0),
    .resp_data(resp_data0), .sck(sck0), .ss(ss0), .mosi(mosi0), .miso(miso0)
  );

  spi_byte_master #(.DIV(1), .MAXLEN(16)) dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_len(req_len), .req_data(req_data), .resp_valid(resp_valid1),
    .resp_data(resp_data1), .sck(sck1), .ss(ss1), .mosi(mosi1), .miso(miso1)
  );

  // Slave: shifts out slv_word MSB-first, captures mosi on each sck rise while selected.
  assign slv_miso = (slv_edges < 16) ? slv_word[15 - slv_edges] : 1'b0;
  assign miso0 = (miso_mode == 2'd0) ? mosi0 : (miso_mode == 2'd1) ? 1'b1 : slv_miso;
  assign miso1 = mosi1;

  always @(negedge ss0) begin
    slv_falls = slv_falls + 1;
    slv_edges = 0;
    slv_rx    = '0;
  end

  always @(posedge sck0) begin
    if (ss0 == 1'b0) begin
      slv_edges = slv_edges + 1;
      slv_rx    = {slv_rx[14:0], mosi0};
    end
  end

  always @(posedge clock) if (resp_valid0 === 1'b1) resp_pulses0 = resp_pulses0 + 1;
  always @(posedge clock) if (sck1 === 1'b1) sck1_hi = sck1_hi + 1;
  always @(posedge sck1) edges1 = edges1 + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  len;
    logic [15:0] data;
    logic [1:0]  mode;
    logic [15:0] exp_resp;
    logic [15:0] exp_slv;
    int          exp_lat;
    int          exp_edges;
  } vec_t;

  vec_t vecs[7];

  task automatic wait_accept0();
    int w = 0;
    @(negedge clock);
    while (req_ready0 !== 1'b1 && w < 100) begin
      @(negedge clock);
      w++;
    end
    if (w >= 100) chk("accept_timeout0", 0, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int f0;
    miso_mode  = v.mode;
    req_len    = v.len;
    req_data   = v.data;
    f0         = slv_falls;
    req_valid0 = 1'b1;
    wait_accept0();
    req_valid0 = 1'b0;
    req_data   = 16'hDEAD;
    req_len    = 5'd3;
    lat = 1;
    while (resp_valid0 !== 1'b1 && lat < 300) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_resp_data", idx), resp_data0, v.exp_resp);
    chk($sformatf("v%0d_sck_edges", idx), slv_edges, v.exp_edges);
    chk($sformatf("v%0d_mosi_stream", idx), slv_rx, v.exp_slv);
    chk($sformatf("v%0d_ss_falls", idx), slv_falls - f0, 1);
    chk($sformatf("v%0d_ss_done", idx), ss0, 1'b1);
    chk($sformatf("v%0d_mosi_done", idx), mosi0, 1'b1);
    @(posedge clock);
    #1;
    chk($sformatf("v%0d_resp_pulse_end", idx), resp_valid0, 1'b0);
    chk($sformatf("v%0d_ready_after", idx), req_ready0, 1'b1);
  endtask

  initial begin
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    req_len    = 5'd8;
    req_data   = '0;
    miso_mode  = 2'd0;
    slv_word   = 16'h1234;

    //              len    data      mode  resp      slave rx  lat edges
    vecs[0] = '{5'd8,  16'hA5A5 & 16'h00A5, 2'd0, 16'h00A5, 16'h00A5, 35, 8};
    vecs[1] = '{5'd16, 16'hB100, 2'd2, 16'h1234, 16'hB100, 67, 16};
    vecs[2] = '{5'd5,  16'h0000, 2'd1, 16'h001F, 16'h0000, 23, 5};
    vecs[3] = '{5'd1,  16'h0001, 2'd0, 16'h0001, 16'h0001, 7,  1};
    vecs[4] = '{5'd0,  16'hFFFF, 2'd0, 16'h0001, 16'h0001, 7,  1};
    vecs[5] = '{5'd20, 16'h8001, 2'd0, 16'h8001, 16'h8001, 67, 16};
    vecs[6] = '{5'd4,  16'hFFF6, 2'd2, 16'h0001, 16'h0006, 19, 4};

    #12;
    chk("rst_req_ready", req_ready0, 1'b1);
    chk("rst_sck", sck0, 1'b0);
    chk("rst_ss", ss0, 1'b1);
    chk("rst_mosi", mosi0, 1'b1);
    chk("rst_resp_valid", resp_valid0, 1'b0);
    chk("rst_resp_data", resp_data0, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Back-to-back: request held through DONE is taken in the following IDLE cycle.
    begin
      int n = 0, cyc = 0, since = 0, gap = 0, p0;
      logic gap_open = 1'b0;
      logic [15:0] r0 = '0, r1 = '0;
      p0 = resp_pulses0;
      miso_mode  = 2'd0;
      req_len    = 5'd8;
      req_data   = 16'h003C;
      req_valid0 = 1'b1;
      wait_accept0();
      req_data = 16'h00C3;
      while (n < 2 && cyc < 300) begin
        @(posedge clock);
        #1;
        cyc++;
        if (n == 1) begin
          since++;
          if (gap_open && ss0 === 1'b1) gap++;
          else gap_open = 1'b0;
          if (since == 2) req_valid0 = 1'b0;
        end
        if (resp_valid0 === 1'b1) begin
          if (n == 0) begin
            r0 = resp_data0;
            since = 0;
            gap = 1;
            gap_open = 1'b1;
          end else begin
            r1 = resp_data0;
          end
          n++;
        end
      end
      req_valid0 = 1'b0;
      chk("b2b_resp_count", n, 2);
      chk("b2b_first", r0, 16'h003C);
      chk("b2b_second", r1, 16'h00C3);
      chk("b2b_ss_gap_ge1", (gap >= 1), 1'b1);
      repeat (100) @(posedge clock);
      #1;
      chk("b2b_no_extra_resp", resp_pulses0 - p0, 2);
    end

    // Reset during the third HIGH phase aborts the frame without a response.
    begin
      int w = 0, p0;
      miso_mode  = 2'd0;
      req_len    = 5'd8;
      req_data   = 16'h00FF;
      req_valid0 = 1'b1;
      wait_accept0();
      req_valid0 = 1'b0;
      while (slv_edges < 3 && w < 200) begin
        @(posedge clock);
        #1;
        w++;
      end
      chk("abort_reached_3rd_high", sck0, 1'b1);
      chk("abort_edge_count", slv_edges, 3);
      p0 = resp_pulses0;
      #2;
      reset = 1'b1;
      #1;
      chk("abort_sck", sck0, 1'b0);
      chk("abort_ss", ss0, 1'b1);
      chk("abort_req_ready", req_ready0, 1'b1);
      chk("abort_resp_valid", resp_valid0, 1'b0);
      chk("abort_resp_data", resp_data0, 16'h0000);
      @(negedge clock);
      reset = 1'b0;
      repeat (60) @(posedge clock);
      #1;
      chk("abort_no_resp", resp_pulses0 - p0, 0);
      chk("abort_idle_ss", ss0, 1'b1);
      chk("abort_idle_sck", sck0, 1'b0);
    end

    // DIV=1: single one-clock sck pulse, latency 4.
    begin
      int lat = 1, w = 0, e0, h0;
      e0 = edges1;
      h0 = sck1_hi;
      req_len    = 5'd1;
      req_data   = 16'h0001;
      req_valid1 = 1'b1;
      @(negedge clock);
      while (req_ready1 !== 1'b1 && w < 100) begin
        @(negedge clock);
        w++;
      end
      @(posedge clock);
      #1;
      req_valid1 = 1'b0;
      while (resp_valid1 !== 1'b1 && lat < 100) begin
        @(posedge clock);
        #1;
        lat++;
      end
      chk("div1_latency", lat, 4);
      chk("div1_resp_data", resp_data1, 16'h0001);
      repeat (3) @(posedge clock);
      #1;
      chk("div1_sck_edges", edges1 - e0, 1);
      chk("div1_sck_high_clocks", sck1_hi - h0, 1);
      chk("div1_ss_idle", ss1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
